// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-code constants, op-class decode, flag bit indices and condition codes.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ENTRY_W = 41;

    typedef enum logic [1:0] {CLS_ARITH, CLS_LOGIC, CLS_ILLEGAL} op_class_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_CMP}) ? CLS_ARITH :
               (op inside {OP_AND, OP_OR, OP_XOR, OP_SLT, OP_NOR, OP_NAND}) ? CLS_LOGIC : CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: 2-entry shift FIFO; slot 0 is the head and keeps its last value when empty.
module alu_result_fifo
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ENTRY_W-1:0] din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] dout
);

    logic [ENTRY_W-1:0] e0, e1;
    logic [1:0] count;
    logic push, pop;

    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dout      = e0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'd2) begin
                e0 <= e1;
                if (push) e1 <= din;
            end else if (push) begin
                if (count == 2'd0 || pop) e0 <= din;
                else e1 <= din;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: status-register update, flag sanitising, condition evaluation and
// result queueing toward writeback.
module alu_result_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        flags_load,
    input  logic [3:0]  flags_din,
    input  logic [3:0]  cond_sel,
    output logic        cond_true,
    output logic [3:0]  flags_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_flags,
    output logic [3:0]  out_op,
    output logic        out_illegal
);

    op_class_t cls;
    logic [3:0] nf;
    logic n, z, c, v;

    assign cls = op_class(alu_op);
    // Logic ops carry C/V forward so undefined ALU carry/overflow never reaches state.
    assign nf = cls == CLS_ARITH ? {alu_n, alu_z, alu_c, alu_v} :
                cls == CLS_LOGIC ? {alu_n, alu_z, flags_q[FLAG_C], flags_q[FLAG_V]} : flags_q;

    always_ff @(posedge clk) begin
        if (!rst_n) flags_q <= '0;
        else if (flags_load) flags_q <= flags_din;
        else if (in_valid && in_ready) flags_q <= nf;
    end

    assign n = flags_q[FLAG_N];
    assign z = flags_q[FLAG_Z];
    assign c = flags_q[FLAG_C];
    assign v = flags_q[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(cond_sel))
            COND_EQ: cond_true = z;
            COND_NE: cond_true = !z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = !c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = !n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = !v;
            COND_HI: cond_true = c && !z;
            COND_LS: cond_true = !c || z;
            COND_GE: cond_true = n == v;
            COND_LT: cond_true = n != v;
            COND_GT: cond_true = !z && (n == v);
            COND_LE: cond_true = z || (n != v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    alu_result_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       ({alu_result, nf, alu_op, cls == CLS_ILLEGAL}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      ({out_data, out_flags, out_op, out_illegal})
    );

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random stimulus against a queue-based reference model.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, alu_c, alu_z, alu_n, alu_v, flags_load;
    logic        cond_true, out_valid, out_ready, out_illegal;
    logic [3:0]  alu_op, flags_din, cond_sel, flags_q, out_flags, out_op;
    logic [31:0] alu_result, out_data;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  f;
        logic [3:0]  op;
        logic        ill;
    } ent_t;

    ent_t       q[$];
    ent_t       last;
    logic [3:0] mflags;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
        .alu_n(alu_n), .alu_v(alu_v), .flags_load(flags_load), .flags_din(flags_din),
        .cond_sel(cond_sel), .cond_true(cond_true), .flags_q(flags_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_op(out_op), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [40:0] got, input logic [40:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] s, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (s)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c & !z;
            4'h9: return !c | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_in(input logic vld, input logic [3:0] op, input logic [31:0] res,
                          input logic n, input logic z, input logic c, input logic v);
        in_valid = vld; alu_op = op; alu_result = res;
        alu_n = n; alu_z = z; alu_c = c; alu_v = v;
    endtask

    // Called just after a falling edge with inputs already driven; advances one clock.
    task automatic step();
        logic acc, pop, arith, logic_op;
        logic [3:0] nf;
        #1;
        check("cond_pre", cond_true, ref_cond(cond_sel, mflags));
        acc      = in_valid && q.size() < 2;
        pop      = out_ready && q.size() > 0;
        arith    = alu_op inside {4'b0010, 4'b0110, 4'b1010};
        logic_op = alu_op inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1100, 4'b1101};
        nf       = arith ? {alu_n, alu_z, alu_c, alu_v} : logic_op ? {alu_n, alu_z, mflags[1:0]} : mflags;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mflags = 4'b0000;
            last = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{alu_result, nf, alu_op, !(arith || logic_op)});
            if (flags_load) mflags = flags_din;
            else if (acc) mflags = nf;
        end
        if (q.size() > 0) last = q[0];
        #1;
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        check("flags_q", flags_q, mflags);
        check("cond_post", cond_true, ref_cond(cond_sel, mflags));
        check("head", {out_data, out_flags, out_op, out_illegal}, last);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; flags_load = 1'b0; flags_din = 4'h0; cond_sel = 4'hE;
        set_in(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_al", cond_true, 1'b1);
        cond_sel = 4'hF;
        step();
        check("idle_nv", cond_true, 1'b0);
        // ADD result 0 with carry -> 0110, EQ true
        cond_sel = 4'h0;
        set_in(1'b1, 4'b0010, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("add_flags", out_flags, 4'b0110);
        check("add_eq", cond_true, 1'b1);
        // logic op with undefined C/V keeps committed C/V
        out_ready = 1'b1;
        set_in(1'b1, 4'b0000, 32'h8000_0000, 1'b1, 1'b0, 1'bx, 1'bx);
        step();
        check("logic_flags", flags_q, 4'b1010);
        check("logic_out_x", ^{out_data, out_flags, out_op, out_illegal, flags_q, cond_true} !== 1'bx, 1'b1);
        set_in(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        // backpressure: three pushes, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 4'b0110, 32'h100 + i, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 3) alu_result = 32'h102;
            if (i >= 2) alu_result = 32'h102;
            step();
        end
        check("full_hold", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        set_in(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        // load wins over accept for flags_q, entry keeps op flags
        out_ready = 1'b0;
        set_in(1'b1, 4'b1010, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        flags_load = 1'b1; flags_din = 4'b1100;
        step();
        check("load_flags_q", flags_q, 4'b1100);
        check("load_entry", out_flags, 4'b0001);
        flags_load = 1'b0;
        set_in(1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
        out_ready = 1'b1;
        step();
        set_in(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("illegal", out_illegal, 1'b1);
        check("illegal_flags", flags_q, 4'b1100);
        // reset with two entries queued
        out_ready = 1'b0;
        set_in(1'b1, 4'b0001, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b0;
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 2) != 0, 4'($urandom), $urandom,
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready  = $urandom_range(0, 2) != 0;
            flags_load = $urandom_range(0, 9) == 0;
            flags_din  = 4'($urandom);
            cond_sel   = 4'($urandom);
            rst_n      = $urandom_range(0, 49) != 0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Downstream stage that consumes the combinational ALU's result and NZCV flags each cycle an operation is issued. Maintains the architectural status register and sanitises undefined carry/overflow from logic operations. Buffers result+flags in a 2-entry queue toward writeback with a valid/ready handshake. Also evaluates a 4-bit branch condition against the committed flags.

## Interface
- No parameters; data width fixed at 32, queue depth fixed at 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  ALU result presented this cycle.
- `in_ready`  out  1  stage can accept; equals `count != 2`.
- `alu_op`  in  4  ALUCntl code that produced the result.
- `alu_result`  in  32  ALU result.
- `alu_c`, `alu_z`, `alu_n`, `alu_v`  in  1 each  ALU flags; C/V may be X for logic ops.
- `flags_load`  in  1  overwrite the status register (context restore).
- `flags_din`  in  4  {N,Z,C,V} value for `flags_load`.
- `cond_sel`  in  4  condition code to evaluate.
- `cond_true`  out  1  condition result against `flags_q`.
- `flags_q`  out  4  committed {N,Z,C,V}.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  32  head result.
- `out_flags`  out  4  head {N,Z,C,V} (status after that op).
- `out_op`  out  4  head op code.
- `out_illegal`  out  1  head op code not recognised.

## Operation
- Accept: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Op classes, by `alu_op`:
  - Arithmetic 0010, 0110, 1010: N, Z, C, V all taken from the ALU.
  - Logic 0000, 0001, 0011, 0111, 1100, 1101: N and Z from the ALU; C and V keep their `flags_q` values. ALU C/V are never sampled for these ops.
  - Any other code: flags unchanged; entry pushed with `out_illegal=1`; `alu_result` stored as-is.
- On accept, the new flag value is computed and written to `flags_q` and into the entry's flag field.
- `flags_load` alone: `flags_q <= flags_din`.
- `flags_load` on an accept cycle: `flags_q <= flags_din` (load wins). The pushed entry still records the op-computed flags.
- `cond_true` is combinational from `flags_q`; `cond_sel` encodings:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- Queue: 2 entries, FIFO order, 2-bit `count`. A push and a pop in the same cycle leave `count` unchanged.
- When full, `in_ready=0` even if a pop occurs that cycle (no combinational ready path).

## Timing
- Reset, applied at the clock edge while `rst_n=0`:
  - `count=0`, `out_valid=0`, `in_ready=1`, `flags_q=0000`.
  - `out_data=0`, `out_flags=0`, `out_op=0`, `out_illegal=0`.
- Reset mid-operation discards queued entries and any concurrent accept.
- Latency: op accepted at edge t is visible at the queue head (`out_valid=1`) after edge t, when the queue was empty. `flags_q` and `cond_true` reflect it after the same edge.
- Head outputs are held stable while `out_valid && !out_ready`.
- `out_data`/`out_flags`/`out_op`/`out_illegal` hold their last value when `out_valid=0`; they are never X.

## Structure
- `alu_pkg`: op-code constants, op-class decode function, flag bit indices (N=3, Z=2, C=1, V=0), `cond_sel` encodings.
- Sub-module `alu_result_fifo`: 2-entry, 41-bit-wide synchronous FIFO with count/valid/ready.
- Flag update and condition logic stay in the top module.

## Test plan
- Reset then idle: `flags_q=0000`, `out_valid=0`, `in_ready=1`, `cond_true=1` for `cond_sel=E` and 0 for F.
- Op 0010 with result 0, C=1, V=0, N=0 -> head `out_flags=0110`, `flags_q=0110`; `cond_sel=0` (EQ) -> `cond_true=1`.
- After the previous op, logic op 0000 with result 0x80000000 and C=V=X -> `flags_q=1010`, no X on any output.
- Push 3 ops with `out_ready=0` -> `in_ready=0` after the second push; third held. Raise `out_ready` -> entries drain in order, third accepted one cycle after `in_ready` rises.
- Accept op 1010 (flags 0001) in the same cycle as `flags_load` with `flags_din=1100` -> `flags_q=1100`, entry `out_flags=0001`.
- Op 1111 -> `out_illegal=1`, `flags_q` unchanged. Assert `rst_n=0` with 2 entries queued -> next cycle `out_valid=0`, `count=0`.
